wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback requesters:
//  req0 (ALU result) and req1 (load/CSR result).
//  - Each requester has a valid/ready handshake and a one-entry holding register.
//  - A per-cycle arbiter picks one pending entry and drives registered write-port
//    signals (wr_en/wr_addr/wr_data) straight into the register file write inputs.
// PARAMETERS
//  ADDR_WIDTH  5   register index width (32 registers)
//  DATA_WIDTH  32  register data width
// PORTS
//  clk         in   1           clock, all state updates on rising edge
//  reset       in   1           synchronous, active-high reset
//  flush       in   1           discard all pending (not yet issued) writes
//  req0_valid  in   1           requester 0 has a write
//  req0_ready  out  1           requester 0 write accepted this cycle if valid
//  req0_addr   in   ADDR_WIDTH  requester 0 destination register
//  req0_data   in   DATA_WIDTH  requester 0 write value
//  req1_valid  in   1           requester 1 has a write
//  req1_ready  out  1           requester 1 write accepted this cycle if valid
//  req1_addr   in   ADDR_WIDTH  requester 1 destination register
//  req1_data   in   DATA_WIDTH  requester 1 write value
//  wr_en       out  1           register file write enable (registered)
//  wr_addr     out  ADDR_WIDTH  register file write index (registered)
//  wr_data     out  DATA_WIDTH  register file write value (registered)
//  busy        out  1           any holding register full or wr_en high
// BEHAVIOUR
//  - Reset (sampled at clk edge while reset=1):
//    - holding regs empty; wr_en=0, wr_addr=0, wr_data=0, busy=0.
//    - RR pointer set so req0 wins the first contention.
//    - reqN_ready=0 while reset=1.
//  - Accept: reqN_ready = !reset && !flush && (!fullN || grantN).
//    - valid&&ready at edge E0 loads holding N; fullN=1 after E0.
//  - Writes to x0 (addr==0) are accepted (ready as above) but never loaded and never
//    reach the write port.
//  - Grant: combinational each cycle over full holding regs. At the next edge:
//    - the granted entry is copied to wr_*, wr_en=1, and its holding reg is cleared,
//      unless refilled by a same-cycle accept.
//    - No entry full -> wr_en=0 at next edge; wr_addr/wr_data hold their last value.
//  - Latency: accept at E0 -> wr_en high after E1 -> register file commits at E2.
//  - Throughput: a lone requester sustains one write per cycle. Combined output is at
//    most one write per cycle.
//  - Same address pending on both requesters: both are written in grant order; the
//    later write's value persists. No merging.
//  - Grant order between different addresses is the only cross-requester ordering
//    provided.
//  - flush=1 at an edge: both holding regs cleared, no new accepts, wr_en=0 after that
//    edge. flush does not retract a wr_en already high.
//  - reset mid-operation: pending writes are lost; wr_en is low from the reset edge.
//  - busy = full0 | full1 | wr_en (registered components only).
// CONFIGURATION
//  WB_ARB_ROUND_ROBIN_EN
//  - Defined: round-robin. On contention, the requester not granted last contention
//    wins; the pointer updates only on contended grants. No starvation.
//  - Undefined: fixed priority, req0 > req1. req1 is granted only when holding 0 is
//    empty; req1 can starve under continuous req0 traffic.
// TESTING
//  - Reset with req0_valid=1 -> ready0=0, wr_en=0, busy=0. After reset: ready0=1.
//  - Lone write: req0 addr=5 data=0xDEADBEEF at E0 -> wr_en=1, wr_addr=5,
//    wr_data=0xDEADBEEF after E1; wr_en=0 after E2.
//  - Contention: both valid at E0 (r0: x3=0x11, r1: x4=0x22):
//    - RR defined: x3 then x4 on consecutive cycles; next contention grants r1 first.
//    - RR undefined: r0 always first.
//  - x0 write: req1 addr=0 data=0xFFFF_FFFF -> ready1=1, wr_en never asserted,
//    busy stays 0.
//  - Flush: both holding full, flush=1 at E1 -> wr_en=0 after E1, busy=0,
//    ready0/ready1=0 during the flush cycle.
//  - Back-to-back: req0 valid 8 cycles, addr 1..8 -> wr_en high 8 consecutive cycles,
//    addresses 1..8 in order.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file write port between two writeback requesters (round-robin under WB_ARB_ROUND_ROBIN_EN, else fixed req0 > req1)
module wb_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);
  logic                  full0, full1, grant0, grant1, acc0, acc1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] data0, data1;
`ifdef WB_ARB_ROUND_ROBIN_EN
  // prio1 set means req1 wins the next contention
  logic prio1;
  assign grant0 = !flush && full0 && (!full1 || !prio1);
  assign grant1 = !flush && full1 && (!full0 || prio1);
  always_ff @(posedge clk)
    if (reset) prio1 <= 1'b0;
    else if (!flush && full0 && full1) prio1 <= grant0;
`else
  assign grant0 = !flush && full0;
  assign grant1 = !flush && full1 && !full0;
`endif
  assign req0_ready = !reset && !flush && (!full0 || grant0);
  assign req1_ready = !reset && !flush && (!full1 || grant1);
  // x0 writes are handshaken but dropped here
  assign acc0 = req0_valid && req0_ready && (req0_addr != '0);
  assign acc1 = req1_valid && req1_ready && (req1_addr != '0);
  assign busy = full0 || full1 || wr_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      full0   <= 1'b0;
      full1   <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      full0 <= acc0 || (full0 && !grant0 && !flush);
      full1 <= acc1 || (full1 && !grant1 && !flush);
      wr_en <= grant0 || grant1;
      if (grant0 || grant1) begin
        wr_addr <= grant0 ? addr0 : addr1;
        wr_data <= grant0 ? data0 : data1;
      end
    end
    if (acc0) begin
      addr0 <= req0_addr;
      data0 <= req0_data;
    end
    if (acc1) begin
      addr1 <= req1_addr;
      data1 <= req1_data;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector bench for wb_port_arbiter; expectations follow WB_ARB_ROUND_ROBIN_EN
module tb_wb_port_arbiter;
  typedef struct {
    logic        rst, fl, v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0, r1, en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bz;
  } vec_t;
`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  // second contention: round-robin lets req1 (x7) go first
  localparam logic [4:0]  FA = RR ? 5'd7 : 5'd6;
  localparam logic [31:0] FD = RR ? 32'h44 : 32'h33;
  localparam logic [4:0]  SA = RR ? 5'd6 : 5'd7;
  localparam logic [31:0] SD = RR ? 32'h33 : 32'h44;
  logic clk = 1'b0, reset, flush, req0_valid, req0_ready, req1_valid, req1_ready, wr_en, busy;
  logic [4:0]  req0_addr, req1_addr, wr_addr;
  logic [31:0] req0_data, req1_data, wr_data;
  int checks = 0, errors = 0;
  vec_t tv[17];
  wb_port_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    reset = v.rst; flush = v.fl;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    chk({tag, " req0_ready"}, 32'(req0_ready), 32'(v.r0));
    chk({tag, " req1_ready"}, 32'(req1_ready), 32'(v.r1));
    @(posedge clk);
    #1;
    chk({tag, " wr_en"}, 32'(wr_en), 32'(v.en));
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(v.wa));
    chk({tag, " wr_data"}, wr_data, v.wd);
    chk({tag, " busy"}, 32'(busy), 32'(v.bz));
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    //         rst fl v0 a0    d0            v1 a1     d1            r0  r1     en wa     wd            bz
    tv[0]  = '{1, 0, 1, 5'd5,  32'h1,        0, 5'd0,  32'h0,        0,  0,     0, 5'd0,  32'h0,        0};
    tv[1]  = '{0, 0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1,  1,     0, 5'd0,  32'h0,        1};
    tv[2]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     1, 5'd5,  32'hDEADBEEF, 1};
    tv[3]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     0, 5'd5,  32'hDEADBEEF, 0};
    tv[4]  = '{0, 0, 1, 5'd3,  32'h11,       1, 5'd4,  32'h22,       1,  1,     0, 5'd5,  32'hDEADBEEF, 1};
    tv[5]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  0,     1, 5'd3,  32'h11,       1};
    tv[6]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     1, 5'd4,  32'h22,       1};
    tv[7]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     0, 5'd4,  32'h22,       0};
    tv[8]  = '{0, 0, 1, 5'd6,  32'h33,       1, 5'd7,  32'h44,       1,  1,     0, 5'd4,  32'h22,       1};
    tv[9]  = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        !RR, RR,   1, FA,    FD,           1};
    tv[10] = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     1, SA,    SD,           1};
    tv[11] = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     0, SA,    SD,           0};
    tv[12] = '{0, 0, 0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 1,  1,     0, SA,    SD,           0};
    tv[13] = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     0, SA,    SD,           0};
    tv[14] = '{0, 0, 1, 5'd9,  32'h55,       1, 5'd10, 32'h66,       1,  1,     0, SA,    SD,           1};
    tv[15] = '{0, 1, 1, 5'd11, 32'h77,       0, 5'd0,  32'h0,        0,  0,     0, SA,    SD,           0};
    tv[16] = '{0, 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1,  1,     0, SA,    SD,           0};
    for (int i = 0; i < 17; i++) step($sformatf("v%0d", i), tv[i]);
    // flush must not pull down a wr_en that is already high
    step("fl_load", '{0, 0, 1, 5'd12, 32'h88, 0, 5'd0, 32'h0, 1, 1, 0, SA, SD, 1});
    step("fl_issue", '{0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 1, 5'd12, 32'h88, 1});
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_keep wr_en", 32'(wr_en), 32'd1);
    step("fl_drop", '{0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd12, 32'h88, 0});
    // reset mid-operation loses pending writes
    step("rs_load", '{0, 0, 1, 5'd13, 32'h99, 1, 5'd14, 32'hAA, 1, 1, 0, 5'd12, 32'h88, 1});
    step("rs_hit", '{1, 0, 1, 5'd15, 32'hBB, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0});
    step("rs_idle", '{0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'h0, 0});
    // lone requester streams x1..x8 one per cycle
    for (int j = 0; j < 10; j++) begin
      logic [4:0] ea;
      ea = (j == 0) ? 5'd0 : (j > 8) ? 5'd8 : 5'(j);
      step($sformatf("b2b%0d", j), '{0, 0, j < 8, 5'(j + 1), 32'(j + 1) << 8, 0, 5'd0, 32'h0,
                                    1, 1, (j >= 1 && j <= 8), ea, 32'(ea) << 8, (j <= 8)});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
